// File: rtl/ceespu_dcache_pkg.sv
// Shared definitions for the ceespu N-way data cache: FSM states, tag-entry
// field layout and a constant log2 helper.
package ceespu_dcache_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WRITEBACK = 3'd2,
    S_REFILL    = 3'd3,
    S_INSTALL   = 3'd4
  } state_t;

  // Tag entry layout: {tag, dirty, valid}
  localparam int TE_VALID = 0;
  localparam int TE_DIRTY = 1;
  localparam int TE_TAG   = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ceespu_dcache_way.sv
// One cache way: valid/dirty/tag per set plus the line data, asynchronous
// read, byte-masked synchronous write, valid/dirty cleared on I_rst.
module ceespu_dcache_way
  import ceespu_dcache_pkg::*;
#(
  parameter int TAG_BITS = 16,
  parameter int SET_BITS = 6,
  parameter int OFF_BITS = 3
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic [SET_BITS-1:0]   I_set,
  input  logic [OFF_BITS-1:0]   I_roff,
  input  logic [OFF_BITS-1:0]   I_woff,
  input  logic                  I_data_we,
  input  logic [3:0]            I_mask,
  input  logic [31:0]           I_wdata,
  input  logic                  I_install,
  input  logic [TAG_BITS-1:0]   I_tag,
  input  logic                  I_set_dirty,
  output logic [TAG_BITS+1:0]   O_entry,
  output logic [31:0]           O_rdata
);
  localparam int SETS  = 1 << SET_BITS;
  localparam int DEPTH = SETS << OFF_BITS;

  logic [SETS-1:0]     r_valid;
  logic [SETS-1:0]     r_dirty;
  logic [TAG_BITS-1:0] r_tag  [SETS];
  logic [31:0]         r_data [DEPTH];
  logic [31:0]         w_old;
  logic [31:0]         w_merged;

  assign O_entry[TE_VALID]             = r_valid[I_set];
  assign O_entry[TE_DIRTY]             = r_dirty[I_set];
  assign O_entry[TE_TAG +: TAG_BITS]   = r_tag[I_set];
  assign O_rdata                       = r_data[{I_set, I_roff}];
  assign w_old                         = r_data[{I_set, I_woff}];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_merged[gi*8 +: 8] = I_mask[gi] ? I_wdata[gi*8 +: 8] : w_old[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (I_install) begin
      r_valid[I_set] <= 1'b1;
      r_dirty[I_set] <= 1'b0;
    end else if (I_set_dirty) begin
      r_dirty[I_set] <= 1'b1;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_install) r_tag[I_set] <= I_tag;
    if (I_data_we) r_data[{I_set, I_woff}] <= w_merged;
  end

endmodule

// File: rtl/ceespu_dcache_nway.sv
// N-way write-back, write-allocate data cache with a single-word beat bus.
// Optional hit/miss counters are built when CEESPU_DCACHE_PERF_EN is defined.
module ceespu_dcache_nway
  import ceespu_dcache_pkg::*;
#(
  parameter int ADDR_BITS  = 25,
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 8
) (
  input  logic                 I_clk,
  input  logic                 I_rst,
  input  logic                 I_memEnable,
  input  logic                 I_isWrite,
  input  logic [ADDR_BITS-1:0] I_address,
  input  logic [3:0]           I_writeMask,
  input  logic [31:0]          I_writeData,
  output logic [31:0]          O_readData,
  output logic                 O_valid,
  output logic                 O_membusy,
  output logic                 O_mem_req,
  output logic                 O_mem_we,
  output logic [ADDR_BITS-1:0] O_mem_addr,
  output logic [31:0]          O_mem_wdata,
  input  logic                 I_mem_ack,
  input  logic [31:0]          I_mem_rdata,
  output logic [31:0]          O_hits,
  output logic [31:0]          O_misses
);
  localparam int OB = clog2(LINE_WORDS);
  localparam int SB = clog2(SETS);
  localparam int TB = ADDR_BITS - SB - OB;
  localparam int WB = (WAYS > 1) ? clog2(WAYS) : 1;

  state_t               r_state, w_state_next;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_is_write;
  logic [3:0]           r_mask;
  logic [31:0]          r_wdata;
  logic [WB-1:0]        r_victim;
  logic [TB-1:0]        r_victim_tag;
  logic [OB-1:0]        r_beat;
  logic [WB-1:0]        r_vptr [SETS];
  logic                 r_valid_out;
  logic [31:0]          r_read_data;
  logic                 r_mem_req, r_mem_we;
  logic [ADDR_BITS-1:0] r_mem_addr;
  logic [31:0]          r_mem_wdata;

  logic [OB-1:0]  w_off, w_roff, w_woff, w_beat_inc;
  logic [SB-1:0]  w_set;
  logic [TB-1:0]  w_tag;
  logic [TB+1:0]  w_entry [WAYS];
  logic [31:0]    w_rdata [WAYS];
  logic [WAYS-1:0] w_data_we, w_install, w_set_dirty;
  logic           w_hit, w_victim_valid, w_victim_dirty, w_beat_ack, w_last_beat;
  logic [WB-1:0]  w_hit_way, w_victim;
  logic [3:0]     w_way_mask;
  logic [31:0]    w_way_wdata;

  assign w_off       = r_addr[OB-1:0];
  assign w_set       = r_addr[OB +: SB];
  assign w_tag       = r_addr[ADDR_BITS-1 -: TB];
  assign w_beat_inc  = r_beat + 1'b1;
  assign w_beat_ack  = r_mem_req & I_mem_ack;
  assign w_last_beat = (r_beat == OB'(LINE_WORDS - 1));
  assign w_woff      = (r_state == S_REFILL) ? r_beat : w_off;
  assign w_way_mask  = (r_state == S_REFILL) ? 4'hF : r_mask;
  assign w_way_wdata = (r_state == S_REFILL) ? I_mem_rdata : r_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      assign w_data_we[gi]   = (r_state == S_LOOKUP && w_hit && r_is_write && w_hit_way == WB'(gi)) ||
                               (r_state == S_REFILL && w_beat_ack && r_victim == WB'(gi));
      assign w_set_dirty[gi] = r_state == S_LOOKUP && w_hit && r_is_write && w_hit_way == WB'(gi);
      assign w_install[gi]   = r_state == S_INSTALL && r_victim == WB'(gi);

      ceespu_dcache_way #(.TAG_BITS(TB), .SET_BITS(SB), .OFF_BITS(OB)) u_way (
        .I_clk(I_clk), .I_rst(I_rst), .I_set(w_set), .I_roff(w_roff), .I_woff(w_woff),
        .I_data_we(w_data_we[gi]), .I_mask(w_way_mask), .I_wdata(w_way_wdata),
        .I_install(w_install[gi]), .I_tag(w_tag), .I_set_dirty(w_set_dirty[gi]),
        .O_entry(w_entry[gi]), .O_rdata(w_rdata[gi])
      );
    end
  endgenerate

  // Descending scan so the lowest matching/invalid way wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_victim  = r_vptr[w_set];
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (w_entry[i][TE_VALID] && w_entry[i][TE_TAG +: TB] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WB'(i);
      end
      if (!w_entry[i][TE_VALID]) w_victim = WB'(i);
    end
  end

  assign w_victim_valid = w_entry[w_victim][TE_VALID];
  assign w_victim_dirty = w_entry[w_victim][TE_DIRTY];

  // On a miss, pre-read word 0 of the victim; during writeback, the next beat.
  always_comb begin
    w_roff = w_off;
    if (r_state == S_LOOKUP && !w_hit) w_roff = '0;
    else if (r_state == S_WRITEBACK) w_roff = w_beat_inc;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (I_memEnable) w_state_next = S_LOOKUP;
      S_LOOKUP: begin
        if (w_hit) w_state_next = S_IDLE;
        else if (w_victim_valid && w_victim_dirty) w_state_next = S_WRITEBACK;
        else w_state_next = S_REFILL;
      end
      S_WRITEBACK: if (w_beat_ack && w_last_beat) w_state_next = S_REFILL;
      S_REFILL:    if (w_beat_ack && w_last_beat) w_state_next = S_INSTALL;
      S_INSTALL:   w_state_next = S_LOOKUP;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_is_write   <= 1'b0;
      r_mask       <= '0;
      r_wdata      <= '0;
      r_victim     <= '0;
      r_victim_tag <= '0;
      r_beat       <= '0;
      r_valid_out  <= 1'b0;
      r_read_data  <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      for (int i = 0; i < SETS; i++) r_vptr[i] <= '0;
    end else begin
      r_state     <= w_state_next;
      r_valid_out <= 1'b0;
      case (r_state)
        S_IDLE: if (I_memEnable) begin
          r_addr     <= I_address;
          r_is_write <= I_isWrite;
          r_mask     <= I_writeMask;
          r_wdata    <= I_writeData;
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_valid_out <= 1'b1;
            if (!r_is_write) r_read_data <= w_rdata[w_hit_way];
          end else begin
            r_victim     <= w_victim;
            r_victim_tag <= w_entry[w_victim][TE_TAG +: TB];
            r_beat       <= '0;
            r_mem_req    <= 1'b1;
            if (w_victim_valid) r_vptr[w_set] <= (WAYS > 1) ? r_vptr[w_set] + 1'b1 : '0;
            if (w_victim_valid && w_victim_dirty) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= {w_entry[w_victim][TE_TAG +: TB], w_set, {OB{1'b0}}};
              r_mem_wdata <= w_rdata[w_victim];
            end else begin
              r_mem_we   <= 1'b0;
              r_mem_addr <= {w_tag, w_set, {OB{1'b0}}};
            end
          end
        end
        S_WRITEBACK: if (w_beat_ack) begin
          r_beat <= w_beat_inc;
          if (w_last_beat) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= {w_tag, w_set, {OB{1'b0}}};
          end else begin
            r_mem_addr  <= {r_victim_tag, w_set, w_beat_inc};
            r_mem_wdata <= w_rdata[r_victim];
          end
        end
        S_REFILL: if (w_beat_ack) begin
          r_beat <= w_beat_inc;
          if (w_last_beat) r_mem_req <= 1'b0;
          else r_mem_addr <= {w_tag, w_set, w_beat_inc};
        end
        default: ;
      endcase
    end
  end

  assign O_readData  = r_read_data;
  assign O_valid     = r_valid_out;
  assign O_membusy   = (r_state != S_IDLE);
  assign O_mem_req   = r_mem_req;
  assign O_mem_we    = r_mem_we;
  assign O_mem_addr  = r_mem_addr;
  assign O_mem_wdata = r_mem_wdata;

`ifdef CEESPU_DCACHE_PERF_EN
  logic        r_first;
  logic [31:0] r_hits, r_misses;

  // Only the first lookup of an access counts; the post-install re-lookup does not.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_first  <= 1'b0;
      r_hits   <= '0;
      r_misses <= '0;
    end else if (r_state == S_IDLE && I_memEnable) begin
      r_first <= 1'b1;
    end else if (r_state == S_LOOKUP) begin
      r_first <= 1'b0;
      if (r_first) begin
        if (w_hit) r_hits <= r_hits + 1'b1;
        else r_misses <= r_misses + 1'b1;
      end
    end
  end

  assign O_hits   = r_hits;
  assign O_misses = r_misses;
`else
  assign O_hits   = '0;
  assign O_misses = '0;
`endif

endmodule

// File: doc/ceespu_dcache_nway.md
# ceespu_dcache_nway

Parametrised N-way set-associative, write-back, write-allocate data cache for the ceespu load/store stage. It sits between the core's memory port and the SDRAM controller. Tag, state and data arrays are internal, so the block needs no external RAM. Dirty victims are written back and missing lines are refilled over a single-word request/acknowledge bus, one word per beat.

## Interface
Parameters:
- ADDR_BITS, 25, word-address width; the address is split into tag | set | offset.
- WAYS, 2, associativity; must be a power of two, 1..4.
- SETS, 64, sets per way; must be a power of two.
- LINE_WORDS, 8, 32-bit words per line; must be a power of two, at least 2.

Ports (one clock; reset is synchronous and active-high):
- I_clk  in  1  clock.
- I_rst  in  1  synchronous active-high reset.
- I_memEnable  in  1  request strobe; sampled only in IDLE.
- I_isWrite  in  1  1 = store, 0 = load.
- I_address  in  ADDR_BITS  word address.
- I_writeMask  in  4  byte enables for a store.
- I_writeData  in  32  store data.
- O_readData  out  32  load data; valid while O_valid is high.
- O_valid  out  1  one-cycle completion pulse for both loads and stores.
- O_membusy  out  1  high whenever state != IDLE.
- O_mem_req  out  1  memory beat request.
- O_mem_we  out  1  1 = writeback beat, 0 = refill beat.
- O_mem_addr  out  ADDR_BITS  word address of the current beat.
- O_mem_wdata  out  32  writeback data.
- I_mem_ack  in  1  beat complete; meaningful only while O_mem_req is high.
- I_mem_rdata  in  32  refill data; valid with I_mem_ack.
- O_hits, O_misses  out  32  performance counters (see Configuration).

## Operation
- Address split:
  - offset = I_address[OB-1:0], where OB = log2(LINE_WORDS).
  - set = next log2(SETS) bits.
  - tag = remaining upper bits.
- Per line state: valid, dirty, tag.
- Per set state: round-robin victim pointer, log2(WAYS) bits.
- States: IDLE, LOOKUP, WRITEBACK, REFILL, INSTALL.
- IDLE:
  - On I_memEnable, latch address, isWrite, mask and data, then go to LOOKUP.
  - I_memEnable outside IDLE is ignored.
- LOOKUP, hit (a valid way with matching tag):
  - Load: register the word to O_readData.
  - Store: merge the masked bytes into the line and set dirty.
  - Either way, pulse O_valid the next cycle and return to IDLE.
  - A hit does not change the victim pointer.
- LOOKUP, miss:
  - Victim = first invalid way (lowest index); otherwise the way at the set's victim pointer.
  - Go to WRITEBACK if the victim is valid and dirty, else to REFILL.
  - Increment the set's victim pointer modulo WAYS only when a valid line is evicted.
- WRITEBACK:
  - LINE_WORDS beats with O_mem_we=1.
  - O_mem_addr = {victim tag, set, beat}; beat counts 0..LINE_WORDS-1.
  - Advance on I_mem_ack; after the last ack go to REFILL.
- REFILL:
  - LINE_WORDS beats with O_mem_we=0 at {request tag, set, beat}.
  - Write I_mem_rdata into the victim way on each ack.
- INSTALL:
  - Set valid=1, dirty=0, tag=request tag.
  - Return to LOOKUP; the re-lookup always hits and completes the access.
- Counters: O_hits increments on each first-pass LOOKUP hit, O_misses on each first-pass miss. The re-lookup after INSTALL is not counted. Both counters wrap modulo 2^32.

## Timing
- Reset values:
  - State IDLE; all valid and dirty bits 0; victim pointers 0.
  - O_valid=0, O_membusy=0, O_mem_req=0, O_mem_we=0.
  - O_mem_addr=0, O_mem_wdata=0, O_readData=0, counters 0.
- Hit latency: request sampled at cycle 0, LOOKUP at cycle 1, O_valid at cycle 2.
- Back-to-back: the next request is accepted at cycle 2 (IDLE again).
- Clean-miss latency: 2 + (LINE_WORDS beats × ack latency) + 1 (INSTALL) + 1 (LOOKUP) + 1 cycles.
- Memory handshake:
  - O_mem_req, O_mem_addr, O_mem_we and O_mem_wdata are registered.
  - They stay stable while O_mem_req=1 and I_mem_ack=0.
  - Back-to-back acks complete one beat per cycle; O_mem_req stays high between beats of one line.
- Reset in mid-transfer: on the cycle after I_rst, O_mem_req=0 and the transfer is abandoned. The memory controller must tolerate the abort.
- O_membusy rises the cycle after acceptance and falls with the O_valid cycle.

## Configuration
- CEESPU_DCACHE_PERF_EN defined: the hit and miss counters are built as described under Operation.
- Not defined: O_hits and O_misses are constant 0 and no counter logic is generated.

## Structure
- Package ceespu_dcache_pkg holds:
  - the state encoding constants;
  - the clog2 helper function;
  - the tag-entry field offsets (valid, dirty, tag).
- Sub-module ceespu_dcache_way, instantiated WAYS times:
  - holds one way's tag/valid/dirty arrays and data array;
  - asynchronous read;
  - synchronous write with byte mask and word select;
  - synchronous valid clear on I_rst.
- The top level holds the FSM, victim selection, beat counter, memory interface and counters.

## Test plan
All scenarios use WAYS=2, SETS=64, LINE_WORDS=8.
- Cold read after reset: load 0x000103 → 8 refill beats at 0x000100..0x000107, no writeback; O_valid returns the word supplied at beat 3.
- Hit: load 0x000105 right after the cold read → O_valid 2 cycles after the request, O_mem_req never asserts.
- Masked store: word holds 0x11223344; store 0xAABBCCDD with mask 4'b0011 to it → a later load returns 0x1122CCDD, no memory traffic.
- Dirty eviction: dirty line at 0x000100, then misses to 0x000300 and 0x000500 (both set 0x20) → 8 write beats at 0x000100..0x000107 carrying the stored data, then refill of 0x000500.
- Ack stalls: hold I_mem_ack low for 0–5 random cycles per beat → O_mem_addr, O_mem_wdata and O_mem_we are constant while waiting; data is correct afterwards.
- Reset at refill beat 4 → the next cycle has O_mem_req=0 and O_membusy=0; a reload of the same address misses again. With CEESPU_DCACHE_PERF_EN, the counters read 0 after reset.
